spi_flash_seq: RTL

- Bus-master sequencer that drives the SPI master peripheral's register interface to run one complete serial-flash transaction per start pulse.
- Transaction format: command byte, optional 24-bit address, then N read bytes.
- Handles chip-select, per-byte start/poll/readback, and back-pressured delivery of received bytes.
- Sits between a flash-boot/DMA client and the SPI master, replacing CPU-driven polling.

---
 rtl/spi_flash_seq.sv | 309 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/spi_flash_seq.sv
// spi_flash_seq
// -----------------------------------------------------------------------------
// Bus-master sequencer that runs one complete serial-flash transaction on an
// SPI master peripheral per start pulse: command byte, optional 24-bit address
// (MSB first), then len_i read bytes. For every byte it loads the SPI DATA
// register, kicks CTRL.go, polls STATUS[0] high then low, and reads DATA back.
// Bytes from read phases are offered to a consumer with a valid/ready
// handshake. Chip-select stays asserted from the first CTRL write until the
// final deselect write, including while the consumer stalls.
//
// Ports
//   clk, rst     : clock, synchronous active-low reset
//   start_i      : one-cycle request, only sampled while idle
//   cmd_i        : command byte
//   faddr_i      : 24-bit flash address
//   addr_en_i    : send three address bytes after the command
//   len_i        : number of read bytes (0 = write-only transaction)
//   busy_o       : transaction in progress (low again in the done cycle)
//   done_o       : one-cycle pulse at the end of a transaction
//   rx_valid_o   : received byte available on rx_data_o
//   rx_data_o    : received byte
//   rx_ready_i   : consumer accepts the byte when rx_valid_o && rx_ready_i
//   m_req_o      : register-bus request (registered)
//   m_we_o       : register-bus write strobe (registered)
//   m_addr_o     : SPI_BASE + register offset (registered)
//   m_data_o     : register-bus write data (registered)
//   m_data_i     : combinational read data from the SPI master
// -----------------------------------------------------------------------------
module spi_flash_seq #(
    parameter logic [31:0] SPI_BASE = 32'h0000_0000,
    parameter logic [7:0]  CLK_DIV  = 8'd1,
    parameter logic        CPOL     = 1'b0,
    parameter logic        CPHA     = 1'b0,
    parameter int          LEN_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [7:0]       cmd_i,
    input  logic [23:0]      faddr_i,
    input  logic             addr_en_i,
    input  logic [LEN_W-1:0] len_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             rx_valid_o,
    output logic [7:0]       rx_data_o,
    input  logic             rx_ready_i,
    output logic             m_req_o,
    output logic             m_we_o,
    output logic [31:0]      m_addr_o,
    output logic [31:0]      m_data_o,
    input  logic [31:0]      m_data_i
);

    // Phase counter must hold 1 + 3 + (2^LEN_W - 1) without wrapping.
    localparam int PH_W = LEN_W + 3;

    localparam logic [31:0] ADDR_CTRL   = SPI_BASE + 32'h0000_0000;
    localparam logic [31:0] ADDR_DATA   = SPI_BASE + 32'h0000_0004;
    localparam logic [31:0] ADDR_STATUS = SPI_BASE + 32'h0000_0008;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_SEL     = 4'd1,
        S_LOAD    = 4'd2,
        S_GO      = 4'd3,
        S_WAIT_HI = 4'd4,
        S_WAIT_LO = 4'd5,
        S_CAPTURE = 4'd6,
        S_HOLD    = 4'd7,
        S_NEXT    = 4'd8,
        S_DESEL   = 4'd9,
        S_DONE    = 4'd10
    } state_t;

    // CTRL register image: clock divider, chip-select, mode bits and go.
    function automatic logic [31:0] ctrl_word(input logic ss, input logic go);
        return {16'h0000, CLK_DIV, 4'h0, ss, CPHA, CPOL, go};
    endfunction

    // Byte shifted out in phase k: command, then address bytes, then dummies.
    function automatic logic [7:0] tx_byte(
        input logic [PH_W-1:0] k,
        input logic            aen,
        input logic [7:0]      cmd,
        input logic [23:0]     fa
    );
        logic [7:0] b;
        b = 8'h00;
        if (k == {PH_W{1'b0}}) begin
            b = cmd;
        end else if (aen && (k == PH_W'(1))) begin
            b = fa[23:16];
        end else if (aen && (k == PH_W'(2))) begin
            b = fa[15:8];
        end else if (aen && (k == PH_W'(3))) begin
            b = fa[7:0];
        end else begin
            b = 8'h00;
        end
        return b;
    endfunction

    state_t            state;
    state_t            state_nxt;
    logic [7:0]        cmd_lat;
    logic [23:0]       faddr_lat;
    logic              addr_en_lat;
    logic [PH_W-1:0]   phase_total;
    logic [PH_W-1:0]   phase;
    logic [PH_W-1:0]   phase_nxt;
    logic [PH_W-1:0]   header_len;
    logic              accept;
    logic              is_read;

    logic              req_nxt;
    logic              we_nxt;
    logic [31:0]       addr_nxt;
    logic [31:0]       wdata_nxt;
    logic              busy_nxt;
    logic              done_nxt;
    logic              rx_valid_nxt;
    logic [7:0]        rx_data_nxt;

    // Only the low byte of DATA carries received data; STATUS uses bit 0.
    logic              unused_data_bits;
    assign unused_data_bits = ^m_data_i[31:8];

    // Phases before header_len are command/address; the rest are read phases.
    assign header_len = addr_en_lat ? PH_W'(4) : PH_W'(1);
    assign is_read    = (phase >= header_len);

    // Next-state and phase-counter decode
    always_comb begin
        state_nxt = state;
        phase_nxt = phase;
        accept    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_i) begin
                    accept    = 1'b1;
                    phase_nxt = {PH_W{1'b0}};
                    state_nxt = S_SEL;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_SEL:  state_nxt = S_LOAD;
            S_LOAD: state_nxt = S_GO;
            S_GO:   state_nxt = S_WAIT_HI;
            S_WAIT_HI: begin
                // STATUS[0] rises a couple of cycles after go; wait for it
                // so the following low is the end of this byte, not idle.
                if (m_data_i[0]) begin
                    state_nxt = S_WAIT_LO;
                end else begin
                    state_nxt = S_WAIT_HI;
                end
            end
            S_WAIT_LO: begin
                if (!m_data_i[0]) begin
                    state_nxt = S_CAPTURE;
                end else begin
                    state_nxt = S_WAIT_LO;
                end
            end
            S_CAPTURE: begin
                if (is_read) begin
                    state_nxt = S_HOLD;
                end else begin
                    state_nxt = S_NEXT;
                end
            end
            S_HOLD: begin
                if (rx_ready_i) begin
                    state_nxt = S_NEXT;
                end else begin
                    state_nxt = S_HOLD;
                end
            end
            S_NEXT: begin
                phase_nxt = phase + PH_W'(1);
                if ((phase + PH_W'(1)) == phase_total) begin
                    state_nxt = S_DESEL;
                end else begin
                    state_nxt = S_LOAD;
                end
            end
            S_DESEL: state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: begin
                state_nxt = S_IDLE;
                phase_nxt = {PH_W{1'b0}};
            end
        endcase
    end

    // Bus and status outputs for the cycle we are about to enter; registered
    // below so each bus access lines up with the state that owns it.
    always_comb begin
        req_nxt   = 1'b0;
        we_nxt    = 1'b0;
        addr_nxt  = 32'h0000_0000;
        wdata_nxt = 32'h0000_0000;
        case (state_nxt)
            S_SEL: begin
                req_nxt   = 1'b1;
                we_nxt    = 1'b1;
                addr_nxt  = ADDR_CTRL;
                wdata_nxt = ctrl_word(1'b1, 1'b0);
            end
            S_LOAD: begin
                req_nxt   = 1'b1;
                we_nxt    = 1'b1;
                addr_nxt  = ADDR_DATA;
                wdata_nxt = {24'h00_0000,
                             tx_byte(phase_nxt, addr_en_lat, cmd_lat, faddr_lat)};
            end
            S_GO: begin
                req_nxt   = 1'b1;
                we_nxt    = 1'b1;
                addr_nxt  = ADDR_CTRL;
                wdata_nxt = ctrl_word(1'b1, 1'b1);
            end
            S_WAIT_HI, S_WAIT_LO: begin
                req_nxt  = 1'b1;
                addr_nxt = ADDR_STATUS;
            end
            S_CAPTURE: begin
                req_nxt  = 1'b1;
                addr_nxt = ADDR_DATA;
            end
            S_DESEL: begin
                req_nxt   = 1'b1;
                we_nxt    = 1'b1;
                addr_nxt  = ADDR_CTRL;
                wdata_nxt = ctrl_word(1'b0, 1'b0);
            end
            default: begin
                req_nxt   = 1'b0;
                we_nxt    = 1'b0;
                addr_nxt  = 32'h0000_0000;
                wdata_nxt = 32'h0000_0000;
            end
        endcase
        busy_nxt = (state_nxt != S_IDLE) && (state_nxt != S_DONE);
        done_nxt = (state_nxt == S_DONE);
    end

    // Receive holding register: load on a read-phase capture, drop on accept
    always_comb begin
        rx_valid_nxt = rx_valid_o;
        rx_data_nxt  = rx_data_o;
        if ((state == S_CAPTURE) && is_read) begin
            rx_valid_nxt = 1'b1;
            rx_data_nxt  = m_data_i[7:0];
        end else if ((state == S_HOLD) && rx_ready_i) begin
            rx_valid_nxt = 1'b0;
        end else begin
            rx_valid_nxt = rx_valid_o;
        end
    end

    // State register, latched request fields and phase counter
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= S_IDLE;
            phase       <= {PH_W{1'b0}};
            phase_total <= {PH_W{1'b0}};
            cmd_lat     <= 8'h00;
            faddr_lat   <= 24'h00_0000;
            addr_en_lat <= 1'b0;
        end else begin
            state <= state_nxt;
            phase <= phase_nxt;
            if (accept) begin
                cmd_lat     <= cmd_i;
                faddr_lat   <= faddr_i;
                addr_en_lat <= addr_en_i;
                phase_total <= PH_W'(1) + (addr_en_i ? PH_W'(3) : PH_W'(0))
                             + PH_W'(len_i);
            end
        end
    end

    // Registered bus, status and receive outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            m_req_o    <= 1'b0;
            m_we_o     <= 1'b0;
            m_addr_o   <= 32'h0000_0000;
            m_data_o   <= 32'h0000_0000;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            rx_valid_o <= 1'b0;
            rx_data_o  <= 8'h00;
        end else begin
            m_req_o    <= req_nxt;
            m_we_o     <= we_nxt;
            m_addr_o   <= addr_nxt;
            m_data_o   <= wdata_nxt;
            busy_o     <= busy_nxt;
            done_o     <= done_nxt;
            rx_valid_o <= rx_valid_nxt;
            rx_data_o  <= rx_data_nxt;
        end
    end

endmodule
